urv_dm_arbiter: RTL

- Shares the single data-memory bus between two requesters: the core's exec-stage load/store port (c_*) and a host/debug port (h_*).
- Sits between the exec stage / host bridge and the memory bus.
- Serialises transactions through a registered FSM with fixed core priority plus a host anti-starvation counter.
- Aborts any transaction the memory does not acknowledge within a bounded timeout.

---
 rtl/urv_dm_arbiter_if.sv | 49 ++++
 rtl/urv_dm_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/urv_dm_arbiter_if.sv
// Bundle of the core requester, host requester and memory bus signals that
// meet at the data-memory arbiter. The slave modport is the arbiter's view;
// the master modport is the view of the surrounding requesters and memory.
interface urv_dm_arbiter_if;
  // core (exec-stage) port
  logic [31:0] c_addr_i;
  logic [31:0] c_data_s_i;
  logic [3:0]  c_select_i;
  logic        c_load_i;
  logic        c_store_i;
  logic        c_ready_o;
  logic        c_err_o;
  logic [31:0] c_data_l_o;
  // host/debug port
  logic [31:0] h_addr_i;
  logic [31:0] h_data_s_i;
  logic [3:0]  h_select_i;
  logic        h_load_i;
  logic        h_store_i;
  logic        h_ready_o;
  logic        h_err_o;
  logic [31:0] h_data_l_o;
  // memory bus
  logic [31:0] m_addr_o;
  logic [31:0] m_data_s_o;
  logic [3:0]  m_select_o;
  logic        m_load_o;
  logic        m_store_o;
  logic        m_ready_i;
  logic [31:0] m_data_l_i;

  modport slave (
    input  c_addr_i, c_data_s_i, c_select_i, c_load_i, c_store_i,
    output c_ready_o, c_err_o, c_data_l_o,
    input  h_addr_i, h_data_s_i, h_select_i, h_load_i, h_store_i,
    output h_ready_o, h_err_o, h_data_l_o,
    output m_addr_o, m_data_s_o, m_select_o, m_load_o, m_store_o,
    input  m_ready_i, m_data_l_i
  );

  modport master (
    output c_addr_i, c_data_s_i, c_select_i, c_load_i, c_store_i,
    input  c_ready_o, c_err_o, c_data_l_o,
    output h_addr_i, h_data_s_i, h_select_i, h_load_i, h_store_i,
    input  h_ready_o, h_err_o, h_data_l_o,
    input  m_addr_o, m_data_s_o, m_select_o, m_load_o, m_store_o,
    output m_ready_i, m_data_l_i
  );
endinterface

// File: rtl/urv_dm_arbiter.sv
// Data-memory arbiter: serialises core and host load/store transactions onto
// one memory bus. Core has fixed priority, but the host is forced through
// after HOST_MAX_WAIT consecutive core wins. A transaction that the memory
// does not acknowledge within TIMEOUT busy cycles completes with an error.
module urv_dm_arbiter #(
  parameter int HOST_MAX_WAIT = 8,
  parameter int TIMEOUT       = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  urv_dm_arbiter_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_BUSY_C = 3'd1;
  localparam logic [2:0] S_BUSY_H = 3'd2;
  localparam logic [2:0] S_RESP_C = 3'd3;
  localparam logic [2:0] S_RESP_H = 3'd4;

  localparam logic [7:0]  MAX_WAIT = 8'(HOST_MAX_WAIT);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  logic [2:0]  state_q,    state_d;
  logic [7:0]  starve_q,   starve_d;
  logic [15:0] tmo_q,      tmo_d;
  logic [31:0] m_addr_q,   m_addr_d;
  logic [31:0] m_data_s_q, m_data_s_d;
  logic [3:0]  m_select_q, m_select_d;
  logic        m_load_q,   m_load_d;
  logic        m_store_q,  m_store_d;
  logic        c_err_q,    c_err_d;
  logic        h_err_q,    h_err_d;
  logic [31:0] c_data_l_q, c_data_l_d;
  logic [31:0] h_data_l_q, h_data_l_d;

  logic c_req;
  logic h_req;
  logic host_wins;

  assign c_req = bus.c_load_i | bus.c_store_i;
  assign h_req = bus.h_load_i | bus.h_store_i;
  // Host wins when it is alone, or when the core has starved it long enough.
  assign host_wins = h_req & (~c_req | (starve_q == MAX_WAIT));

  // Next-state, arbitration, bus latching and completion logic.
  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    tmo_d      = tmo_q;
    m_addr_d   = m_addr_q;
    m_data_s_d = m_data_s_q;
    m_select_d = m_select_q;
    m_load_d   = m_load_q;
    m_store_d  = m_store_q;
    c_err_d    = c_err_q;
    h_err_d    = h_err_q;
    c_data_l_d = c_data_l_q;
    h_data_l_d = h_data_l_q;

    case (state_q)
      S_IDLE: begin
        tmo_d = '0;
        if (host_wins) begin
          // A simultaneous store request overrides load.
          m_addr_d   = bus.h_addr_i;
          m_data_s_d = bus.h_data_s_i;
          m_select_d = bus.h_select_i;
          m_store_d  = bus.h_store_i;
          m_load_d   = bus.h_load_i & ~bus.h_store_i;
          starve_d   = '0;
          state_d    = S_BUSY_H;
        end else if (c_req) begin
          m_addr_d   = bus.c_addr_i;
          m_data_s_d = bus.c_data_s_i;
          m_select_d = bus.c_select_i;
          m_store_d  = bus.c_store_i;
          m_load_d   = bus.c_load_i & ~bus.c_store_i;
          if (h_req && (starve_q != MAX_WAIT)) begin
            starve_d = starve_q + 8'd1;
          end
          state_d = S_BUSY_C;
        end
      end

      S_BUSY_C, S_BUSY_H: begin
        tmo_d = tmo_q + 16'd1;
        // An acknowledge on the timeout cycle still counts as success.
        if (bus.m_ready_i) begin
          m_load_d  = 1'b0;
          m_store_d = 1'b0;
          if (state_q == S_BUSY_H) begin
            h_err_d = 1'b0;
            if (m_load_q) begin
              h_data_l_d = bus.m_data_l_i;
            end
            state_d = S_RESP_H;
          end else begin
            c_err_d = 1'b0;
            if (m_load_q) begin
              c_data_l_d = bus.m_data_l_i;
            end
            state_d = S_RESP_C;
          end
        end else if (tmo_q == TMO_LAST) begin
          m_load_d  = 1'b0;
          m_store_d = 1'b0;
          if (state_q == S_BUSY_H) begin
            h_err_d    = 1'b1;
            h_data_l_d = '0;
            state_d    = S_RESP_H;
          end else begin
            c_err_d    = 1'b1;
            c_data_l_d = '0;
            state_d    = S_RESP_C;
          end
        end
      end

      // Response cycle: ready pulses, requests are not looked at.
      S_RESP_C: begin
        tmo_d   = '0;
        c_err_d = 1'b0;
        state_d = S_IDLE;
      end

      S_RESP_H: begin
        tmo_d   = '0;
        h_err_d = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        m_load_d  = 1'b0;
        m_store_d = 1'b0;
        tmo_d     = '0;
        state_d   = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      starve_q   <= '0;
      tmo_q      <= '0;
      m_addr_q   <= '0;
      m_data_s_q <= '0;
      m_select_q <= '0;
      m_load_q   <= 1'b0;
      m_store_q  <= 1'b0;
      c_err_q    <= 1'b0;
      h_err_q    <= 1'b0;
      c_data_l_q <= '0;
      h_data_l_q <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      tmo_q      <= tmo_d;
      m_addr_q   <= m_addr_d;
      m_data_s_q <= m_data_s_d;
      m_select_q <= m_select_d;
      m_load_q   <= m_load_d;
      m_store_q  <= m_store_d;
      c_err_q    <= c_err_d;
      h_err_q    <= h_err_d;
      c_data_l_q <= c_data_l_d;
      h_data_l_q <= h_data_l_d;
    end
  end

  assign bus.m_addr_o   = m_addr_q;
  assign bus.m_data_s_o = m_data_s_q;
  assign bus.m_select_o = m_select_q;
  assign bus.m_load_o   = m_load_q;
  assign bus.m_store_o  = m_store_q;

  assign bus.c_ready_o  = (state_q == S_RESP_C);
  assign bus.h_ready_o  = (state_q == S_RESP_H);
  assign bus.c_err_o    = c_err_q;
  assign bus.h_err_o    = h_err_q;
  assign bus.c_data_l_o = c_data_l_q;
  assign bus.h_data_l_o = h_data_l_q;

endmodule
